ir_frame_decoder: RTL and testbench
===================================

# ir_frame_decoder

Parametrised pulse-width IR frame decoder for the VCR remote input path. It samples the raw IR line, measures each mark (high pulse) in clock cycles and classifies it as a 0 or 1 bit. It assembles FRAME_BITS bits into a word and presents the word on a valid/ready output handshake. Malformed marks, inter-bit gap timeouts and frames dropped under backpressure are reported on an error strobe. It replaces the fixed 32-bit decoder feeding the command-dispatch logic.

## Interface
- FRAME_BITS, 32: bits per frame (2..64).
- CNT_W, 10: mark/space counter width. Counters saturate at 2^CNT_W-1.
- ZERO_MIN, 1 / ZERO_MAX, 9: inclusive mark-length window, in cycles, for a 0 bit.
- ONE_MIN, 13 / ONE_MAX, 18: inclusive mark-length window for a 1 bit. Windows must not overlap.
- GAP_TIMEOUT, 200: maximum space length, in cycles, between marks inside a frame.
- MSB_FIRST, 1: 1 = first received bit lands in frame_data[FRAME_BITS-1]; 0 = first received bit lands in frame_data[0].
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  high permits a new capture to start
- ir_in  in  1  raw asynchronous IR line
- frame_data  out  FRAME_BITS  assembled frame; stable while frame_valid
- frame_valid  out  1  frame available
- frame_ready  in  1  consumer accepts the frame when high together with frame_valid
- err_valid  out  1  one-cycle error strobe
- err_code  out  2  1 = bad mark width; 2 = gap timeout; 3 = overrun. Held until the next err_valid.
- busy  out  1  high in MARK, SPACE or HOLD

## Operation
- ir_in passes through a 2-flop synchroniser to give ir_s. Edge detect compares ir_s with its registered copy. rise and fall are single-cycle flags.
- States:
  - IDLE: bit_cnt = 0, shift register cleared. On rise with enable = 1: mark_cnt <= 1, go to MARK. On rise with enable = 0: stay in IDLE.
  - MARK: each cycle with ir_s = 1, mark_cnt increments (saturating). On fall, classify mark_cnt:
    - in the 0 window: shift in 0, bit_cnt++.
    - in the 1 window: shift in 1, bit_cnt++.
    - otherwise: err_code = 1, go to IDLE.
    - After a successful classification: if bit_cnt reaches FRAME_BITS, load frame_data, go to HOLD. Otherwise space_cnt <= 1, go to SPACE.
  - SPACE: each cycle with ir_s = 0, space_cnt increments. If space_cnt exceeds GAP_TIMEOUT: err_code = 2, go to IDLE. On rise: mark_cnt <= 1, go to MARK.
  - HOLD: frame_valid = 1. On a cycle with frame_ready = 1, the frame is accepted; go to IDLE next cycle. Any rise in HOLD is dropped, raises err_code = 3, and leaves the FSM in HOLD.
- enable = 0 in MARK or SPACE aborts the capture without error: go to IDLE and discard partial bits. enable has no effect in HOLD.
- Every transition into IDLE caused by an error pulses err_valid for one cycle.
- A saturated mark_cnt falls outside both windows and is therefore a bad mark width (err_code 1).

## Timing
- Reset values: frame_data = 0, frame_valid = 0, err_valid = 0, err_code = 0, busy = 0, state = IDLE, all counters 0.
- Latency from an ir_in edge to rise/fall is 2–3 cycles; the synchroniser delay is identical for both edges, so mark length is preserved exactly.
- mark_cnt at fall equals the number of consecutive cycles in which ir_s = 1.
- frame_valid rises 1 cycle after the fall of the last mark; frame_data is registered in that same cycle.
- The handshake completes on the frame_ready && frame_valid cycle; frame_valid is 0 on the next cycle.
- frame_ready may be held high permanently; the minimum HOLD residency is 1 cycle.
- err_valid asserts 1 cycle after the offending fall or timeout cycle.
- If a timeout and a rise occur in the same cycle, the rise wins: the space is valid.
- reset_n low at any point, including mid-frame or in HOLD, returns every output to its reset value immediately and asynchronously. No partial frame survives reset.

## Test plan
- Default parameters; 32 marks of 5/15 cycles (0/1) separated by 10-cycle spaces encoding 0xA5C3_0F96; frame_ready = 1 -> a single frame_valid pulse with frame_data = 0xA5C3_0F96; err_valid never asserts.
- Same stimulus with MSB_FIRST = 0 -> frame_data = bit-reversed word 0x69F0_C3A5.
- Mark of 11 cycles (between the windows) at bit 7 -> err_valid with err_code = 1; FSM back in IDLE; a following valid frame decodes correctly.
- 12 bits received, then ir_in held low for 250 cycles -> err_code = 2 strobe at space_cnt = 201; busy = 0 afterwards.
- frame_ready = 0 for 400 cycles while a second frame arrives -> the first frame is held with frame_data unchanged; err_code = 3 on the first rise; after frame_ready, the FSM returns to IDLE.
- reset_n pulsed low at bit 20 -> all outputs are 0 within the reset; the next full frame decodes with no residue from the aborted bits.

Source files
------------

// File: rtl/ir_frame_if.sv
// Frame-side handshake between the IR frame decoder and its consumer.
// The decoder drives the frame/error signals and the consumer drives frame_ready.
interface ir_frame_if #(
    parameter int FRAME_BITS = 32
);
    logic [FRAME_BITS-1:0] frame_data;
    logic                  frame_valid;
    logic                  frame_ready;
    logic                  err_valid;
    logic [1:0]            err_code;

    modport master (
        output frame_data, frame_valid, err_valid, err_code,
        input  frame_ready
    );
    modport slave (
        input  frame_data, frame_valid, err_valid, err_code,
        output frame_ready
    );
endinterface

// File: rtl/ir_frame_decoder.sv
// Pulse-width IR frame decoder: measures each mark, classifies it as a 0 or 1 bit,
// assembles FRAME_BITS bits and offers the word on a valid/ready handshake.
module ir_frame_decoder #(
    parameter int FRAME_BITS  = 32,
    parameter int CNT_W       = 10,
    parameter int ZERO_MIN    = 1,
    parameter int ZERO_MAX    = 9,
    parameter int ONE_MIN     = 13,
    parameter int ONE_MAX     = 18,
    parameter int GAP_TIMEOUT = 200,
    parameter int MSB_FIRST   = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       ir_in,
    output logic       busy,
    ir_frame_if.master frm
);
    localparam int                BC_W    = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  Z_MIN   = CNT_W'(ZERO_MIN);
    localparam logic [CNT_W-1:0]  Z_MAX   = CNT_W'(ZERO_MAX);
    localparam logic [CNT_W-1:0]  O_MIN   = CNT_W'(ONE_MIN);
    localparam logic [CNT_W-1:0]  O_MAX   = CNT_W'(ONE_MAX);
    localparam logic [CNT_W-1:0]  GAP_T   = CNT_W'(GAP_TIMEOUT);
    localparam logic [BC_W-1:0]   FB_BC   = BC_W'(FRAME_BITS);

    typedef enum logic [1:0] {IDLE, MARK, SPACE, HOLD} state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, ir_s_q, ir_d_q;
    logic                  rise, fall, is_zero, is_one;
    logic [CNT_W-1:0]      mark_cnt_q, mark_cnt_d;
    logic [CNT_W-1:0]      space_cnt_q, space_cnt_d;
    logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [FRAME_BITS-1:0] frame_data_q, frame_data_d;
    logic                  err_valid_q, err_valid_d;
    logic [1:0]            err_code_q, err_code_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [FRAME_BITS-1:0] shift_in(input logic [FRAME_BITS-1:0] v,
                                                        input logic b);
        if (MSB_FIRST != 0) return {v[FRAME_BITS-2:0], b};
        else                return {b, v[FRAME_BITS-1:1]};
    endfunction

    // Same two-flop delay on both edges keeps the measured mark length exact.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            ir_s_q  <= 1'b0;
            ir_d_q  <= 1'b0;
        end else begin
            sync1_q <= ir_in;
            ir_s_q  <= sync1_q;
            ir_d_q  <= ir_s_q;
        end
    end

    assign rise    = ir_s_q & ~ir_d_q;
    assign fall    = ~ir_s_q & ir_d_q;
    assign is_zero = (mark_cnt_q >= Z_MIN) && (mark_cnt_q <= Z_MAX);
    assign is_one  = (mark_cnt_q >= O_MIN) && (mark_cnt_q <= O_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            mark_cnt_q   <= '0;
            space_cnt_q  <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            frame_data_q <= '0;
            err_valid_q  <= 1'b0;
            err_code_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            mark_cnt_q   <= mark_cnt_d;
            space_cnt_q  <= space_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            frame_data_q <= frame_data_d;
            err_valid_q  <= err_valid_d;
            err_code_q   <= err_code_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mark_cnt_d   = mark_cnt_q;
        space_cnt_d  = space_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        frame_data_d = frame_data_q;
        err_valid_d  = 1'b0;
        err_code_d   = err_code_q;
        unique case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                shift_d   = '0;
                if (rise && enable) begin
                    mark_cnt_d = CNT_W'(1);
                    state_d    = MARK;
                end
            end
            MARK: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (fall) begin
                    if (is_zero || is_one) begin
                        shift_d   = shift_in(shift_q, is_one);
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_d == FB_BC) begin
                            frame_data_d = shift_d;
                            state_d      = HOLD;
                        end else begin
                            space_cnt_d = CNT_W'(1);
                            state_d     = SPACE;
                        end
                    end else begin
                        err_valid_d = 1'b1;
                        err_code_d  = 2'd1;
                        state_d     = IDLE;
                    end
                end else if (ir_s_q) begin
                    mark_cnt_d = sat_inc(mark_cnt_q);
                end
            end
            SPACE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (rise) begin
                    // A rise on the timeout cycle still counts as a valid space.
                    mark_cnt_d = CNT_W'(1);
                    state_d    = MARK;
                end else begin
                    space_cnt_d = sat_inc(space_cnt_q);
                    if (space_cnt_q >= GAP_T) begin
                        err_valid_d = 1'b1;
                        err_code_d  = 2'd2;
                        state_d     = IDLE;
                    end
                end
            end
            HOLD: begin
                if (rise) begin
                    err_valid_d = 1'b1;
                    err_code_d  = 2'd3;
                end
                if (frm.frame_ready) state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy            = (state_q != IDLE);
        frm.frame_valid = (state_q == HOLD);
        frm.frame_data  = frame_data_q;
        frm.err_valid   = err_valid_q;
        frm.err_code    = err_code_q;
    end

endmodule

// File: tb/tb_ir_frame_decoder.sv
// Directed bench for ir_frame_decoder: an MSB-first and an LSB-first instance share
// one IR line; frame and error events are logged on the falling clock edge.
module tb_ir_frame_decoder;
    logic clk = 1'b0;
    logic reset_n, enable, ir_in, ready;
    logic busy0, busy1;
    int   n_chk = 0, n_err = 0;
    int   acc0 = 0, acc1 = 0, vld0 = 0, err0 = 0;
    logic [31:0] accd0 = '0, accd1 = '0;

    always #5 clk = ~clk;

    ir_frame_if #(.FRAME_BITS(32)) frm0 ();
    ir_frame_if #(.FRAME_BITS(32)) frm1 ();
    assign frm0.frame_ready = ready;
    assign frm1.frame_ready = ready;

    ir_frame_decoder #(.MSB_FIRST(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .ir_in(ir_in), .busy(busy0), .frm(frm0)
    );
    ir_frame_decoder #(.MSB_FIRST(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .ir_in(ir_in), .busy(busy1), .frm(frm1)
    );

    always @(negedge clk) begin
        if (frm0.frame_valid) vld0++;
        if (frm0.frame_valid && frm0.frame_ready) begin acc0++; accd0 = frm0.frame_data; end
        if (frm1.frame_valid && frm1.frame_ready) begin acc1++; accd1 = frm1.frame_data; end
        if (frm0.err_valid) err0++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts and ends on a falling clock edge; ir_in high for len cycles, then low for gap.
    task automatic send_mark(input int len, input int gap);
        ir_in = 1'b1;
        repeat (len) @(negedge clk);
        ir_in = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] w, input int nbits, input int zl, input int ol);
        for (int i = 0; i < nbits; i++) send_mark(w[31-i] ? ol : zl, 10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a, v, e, n;
        int bad_len [4] = '{10, 12, 19, 1100};
        reset_n = 1'b0; enable = 1'b1; ir_in = 1'b0; ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data",  frm0.frame_data, 0);
        chk("rst_valid", frm0.frame_valid, 0);
        chk("rst_errv",  frm0.err_valid, 0);
        chk("rst_code",  frm0.err_code, 0);
        chk("rst_busy",  busy0, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Nominal frame, both bit orders
        a = acc0; v = vld0; e = err0;
        send_frame(32'hA5C3_0F96, 32, 5, 15);
        repeat (5) @(negedge clk);
        chk("f1_cnt",   acc0 - a, 1);
        chk("f1_vcyc",  vld0 - v, 1);
        chk("f1_msb",   accd0, 32'hA5C3_0F96);
        chk("f1_lsb",   accd1, 32'h69F0_C3A5);
        chk("f1_noerr", err0 - e, 0);
        chk("f1_busy",  busy0, 0);

        // Window edges: 9/13 and 1/18 cycle marks
        send_frame(32'h0F0F_3C3C, 32, 9, 13);
        repeat (5) @(negedge clk);
        chk("edge_9_13", accd0, 32'h0F0F_3C3C);
        send_frame(32'hC0FF_EE01, 32, 1, 18);
        repeat (5) @(negedge clk);
        chk("edge_1_18", accd0, 32'hC0FF_EE01);
        chk("edge_noerr", err0 - e, 0);

        // 11-cycle mark at bit 7
        e = err0;
        send_frame(32'hA5C3_0F96, 7, 5, 15);
        send_mark(11, 10);
        chk("bad_err",  err0 - e, 1);
        chk("bad_code", frm0.err_code, 1);
        chk("bad_busy", busy0, 0);
        a = acc0;
        send_frame(32'h1234_5678, 32, 5, 15);
        repeat (5) @(negedge clk);
        chk("bad_next_cnt",  acc0 - a, 1);
        chk("bad_next_data", accd0, 32'h1234_5678);

        // Out-of-window single marks, including a saturated counter
        foreach (bad_len[k]) begin
            e = err0;
            send_mark(bad_len[k], 10);
            chk($sformatf("len%0d_err", bad_len[k]), err0 - e, 1);
            chk($sformatf("len%0d_code", bad_len[k]), frm0.err_code, 1);
        end

        // Gap: a 200-cycle space is legal, 12 bits then a long low line times out
        e = err0;
        for (int i = 0; i < 12; i++) send_mark(15, (i == 5) ? 200 : ((i == 11) ? 0 : 10));
        chk("gap200_ok",   err0 - e, 0);
        chk("gap200_busy", busy0, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!frm0.err_valid && n < 300);
        // 2 synchroniser cycles + 201 counted low cycles
        chk("gap_lat",  n, 203);
        chk("gap_code", frm0.err_code, 2);
        repeat (50) @(negedge clk);
        chk("gap_err",  err0 - e, 1);
        chk("gap_busy", busy0, 0);

        // Backpressure: second frame arrives while the first is held
        @(posedge clk); #1 ready = 1'b0;
        @(negedge clk);
        a = acc0;
        send_frame(32'h5A5A_1234, 32, 5, 15);
        repeat (5) @(negedge clk);
        chk("ovr_valid", frm0.frame_valid, 1);
        chk("ovr_data",  frm0.frame_data, 32'h5A5A_1234);
        e = err0;
        send_mark(5, 10);
        chk("ovr_first_err", err0 - e, 1);
        chk("ovr_code",      frm0.err_code, 3);
        send_frame(32'hFFFF_FFFE, 31, 5, 15);
        chk("ovr_all_err",  err0 - e, 32);
        chk("ovr_hold",     frm0.frame_data, 32'h5A5A_1234);
        chk("ovr_hold_vld", frm0.frame_valid, 1);
        chk("ovr_not_acc",  acc0 - a, 0);
        @(posedge clk); #1 ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("ovr_acc",      acc0 - a, 1);
        chk("ovr_acc_data", accd0, 32'h5A5A_1234);
        chk("ovr_busy",     busy0, 0);

        // Enable low aborts a capture silently and blocks new captures
        e = err0; a = acc0;
        send_frame(32'hFFFF_0000, 5, 5, 15);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        chk("en_abort_busy", busy0, 0);
        send_mark(15, 10);
        chk("en_idle_busy", busy0, 0);
        chk("en_noerr",     err0 - e, 0);
        enable = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(32'h0000_FFFF, 32, 5, 15);
        repeat (5) @(negedge clk);
        chk("en_next_cnt",  acc0 - a, 1);
        chk("en_next_data", accd0, 32'h0000_FFFF);

        // Asynchronous reset in the middle of bit 20
        send_frame(32'h3C5A_96E1, 20, 5, 15);
        ir_in = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0; ir_in = 1'b0;
        #1;
        chk("arst_busy",  busy0, 0);
        chk("arst_valid", frm0.frame_valid, 0);
        chk("arst_errv",  frm0.err_valid, 0);
        chk("arst_code",  frm0.err_code, 0);
        chk("arst_data",  frm0.frame_data, 0);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        e = err0; a = acc0;
        send_frame(32'h89AB_CDEF, 32, 5, 15);
        repeat (5) @(negedge clk);
        chk("arst_next_cnt", acc0 - a, 1);
        chk("arst_next_msb", accd0, 32'h89AB_CDEF);
        chk("arst_next_lsb", accd1, 32'hF7B3_D591);
        chk("arst_noerr",    err0 - e, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
